cam_soc_sw_scan_ctrl: RTL

Debounced, interrupt-capable 16-bit switch/status input controller for the cam_soc Avalon-MM fabric. It replaces raw free-running sampling of board inputs with sequenced sampling: synchronise, sample on a programmable tick, commit only stable values, capture edges and raise an interrupt to the Nios II. It sits between the board switch pins and the system interconnect as an Avalon-MM slave with read latency 1.

---
 rtl/cam_soc_sw_pkg.sv | 20 ++
 rtl/cam_soc_sw_debounce.sv | 86 ++++++++
 rtl/cam_soc_sw_scan_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/cam_soc_sw_pkg.sv
// Shared definitions for the cam_soc switch scan controller:
// register word addresses, CTRL bit positions and sequencer states.
package cam_soc_sw_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FORCE  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } sw_state_e;

endpackage

// File: rtl/cam_soc_sw_debounce.sv
// Input synchroniser, sample-tick sequencer and two-sample-agreement
// commit logic. data_o holds the debounced value; changed_o pulses for
// one cycle (during COMMIT) on every bit that is about to be committed.
module cam_soc_sw_debounce
  import cam_soc_sw_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic             enable_i,
  input  logic             force_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] changed_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] s0_q, s1_q, data_q;
  logic [CNT_W-1:0] cnt_q;
  sw_state_e        state_q;
  logic [WIDTH-1:0] commit_d;

  // Two-flop synchroniser on the raw board pins, free running.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // A bit commits only when the last two samples agree and differ from DATA.
  always_comb begin
    commit_d = ~(s1_q ^ s0_q) & (s1_q ^ data_q);
  end

  // Sequencer: tick counting, sampling into s1/s0 and committing to DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (enable_i) state_q <= COUNT;
        end
        COUNT: begin
          if (!enable_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (force_i || (cnt_q == CNT_LAST)) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          s0_q    <= s1_q;
          s1_q    <= sync2_q;
          state_q <= COMMIT;
        end
        COMMIT: begin
          data_q  <= data_q ^ commit_d;
          state_q <= enable_i ? COUNT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o    = data_q;
  assign changed_o = (state_q == COMMIT) ? commit_d : '0;

endmodule

// File: rtl/cam_soc_sw_scan_ctrl.sv
// Avalon-MM (read latency 1) debounced switch input controller.
// Register file, read mux and interrupt. Edge capture, interrupt mask
// and irq exist only when CAM_SOC_SW_IRQ_EN is defined; otherwise those
// registers read 0 and irq is tied low.
module cam_soc_sw_scan_ctrl
  import cam_soc_sw_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             enable_q;
  logic             force_q;
  logic [31:0]      rdata_q;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] mask_rd;
  logic [WIDTH-1:0] edge_rd;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  cam_soc_sw_debounce #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .enable_i  (enable_q),
    .force_i   (force_q),
    .data_o    (data),
    .changed_o (changed)
  );

  // CTRL: sticky ENABLE, one-cycle FORCE_SAMPLE pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      force_q  <= 1'b0;
    end else begin
      force_q <= write && (address == ADDR_CTRL) && writedata[CTRL_FORCE];
      if (write && (address == ADDR_CTRL)) enable_q <= writedata[CTRL_ENABLE];
    end
  end

`ifdef CAM_SOC_SW_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] w1c;
  logic             irq_q;

  assign w1c = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Mask, edge flags (a new set beats a same-cycle clear) and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (write && (address == ADDR_IRQMASK)) mask_q <= writedata[WIDTH-1:0];
      edge_q <= (edge_q & ~w1c) | changed;
      irq_q  <= |(edge_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign edge_rd = edge_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign edge_rd = '0;
  assign irq     = 1'b0;
`endif

  // Bits above WIDTH and, without edge capture, the change pulses are unused.
  logic unused_ok;
  assign unused_ok = ^{writedata, changed};

  // Read data registered every cycle from the address mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      case (address)
        ADDR_DATA:    rdata_q <= zext(data);
        ADDR_IRQMASK: rdata_q <= zext(mask_rd);
        ADDR_CTRL:    rdata_q <= {30'd0, 1'b0, enable_q};
        default:      rdata_q <= zext(edge_rd);
      endcase
    end
  end

  assign readdata = rdata_q;

endmodule
